// File: rtl/coproc_arb_pkg.sv
// rtl/coproc_arb_pkg.sv - shared types and constants for the column adder arbiter
// Purpose: FSM state encoding and the cell value returned when the adder hangs.
// Ports:   none (package).
// Config:  ARB_TIMEOUT_EN is consumed by column_adder_arbiter, not here.
package coproc_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ISSUE   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_DELIVER = 3'd3,
      ST_RELEASE = 3'd4
   } arb_state_t;

   // IEEE-754 single quiet NaN, handed back when the watchdog fires.
   localparam logic [31:0] QNAN_CELL = 32'h7FC0_0000;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational rotate-priority encoder
// Purpose: picks the first asserted request scanning ptr, ptr+1, ... wrapping at NUM_REQ.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  PTR_W    index that gets highest priority
//   grant out NUM_REQ  one-hot winner (all zero when no request)
//   idx   out PTR_W    index of the winner
//   any   out 1        at least one request is set
module rr_picker
   import coproc_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [PTR_W-1:0]   idx,
   output logic               any
);

   int w_j;

   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      w_j   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         // Rotated position, wrapped manually so non-power-of-two NUM_REQ works.
         w_j = int'(ptr) + k;
         if (w_j >= NUM_REQ) begin
            w_j = w_j - NUM_REQ;
         end
         if (!any && req[w_j]) begin
            any        = 1'b1;
            grant[w_j] = 1'b1;
            idx        = PTR_W'(w_j);
         end
      end
   end

endmodule

// File: rtl/column_adder_arbiter.sv
// rtl/column_adder_arbiter.sv - round-robin arbiter sharing one column_adder between requesters
// Purpose: latches the winning requester's column, drives the adder ready/ack handshake and
//          returns the reduced cell only to the winner.
// Config:  ARB_TIMEOUT_EN enables a WAIT-state watchdog (TIMEOUT cycles) that returns a qNaN
//          and sets sticky err_timeout; without it err_timeout is tied 0.
// Ports:
//   in_clk        in   1              clock
//   in_reset      in   1              synchronous active-low reset
//   req_valid     in   NUM_REQ        requester i has a column pending
//   req_col       in   NUM_REQ*WIDTH  packed columns, requester i at [i*WIDTH +: WIDTH]
//   rsp_ack       in   NUM_REQ        requester i consumed rsp_cell
//   grant         out  NUM_REQ        one-hot owner for the whole transaction
//   rsp_ready     out  NUM_REQ        result valid for the granted requester
//   rsp_cell      out  CELL_WIDTH     result cell
//   ca_col        out  WIDTH          latched column to the adder
//   ca_ready      out  1              one-cycle start pulse to the adder
//   ca_ack        out  1              one-cycle result acknowledge to the adder
//   ca_out_ready  in   1              adder result valid
//   ca_cell       in   CELL_WIDTH     adder result
//   err_timeout   out  1              sticky watchdog flag
module column_adder_arbiter
   import coproc_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int SIZE       = 4,
   parameter int CELL_WIDTH = 32,
   parameter int WIDTH      = CELL_WIDTH * SIZE,
   parameter int TIMEOUT    = 256
) (
   input  logic                     in_clk,
   input  logic                     in_reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_col,
   input  logic [NUM_REQ-1:0]       rsp_ack,
   output logic [NUM_REQ-1:0]       grant,
   output logic [NUM_REQ-1:0]       rsp_ready,
   output logic [CELL_WIDTH-1:0]    rsp_cell,
   output logic [WIDTH-1:0]         ca_col,
   output logic                     ca_ready,
   output logic                     ca_ack,
   input  logic                     ca_out_ready,
   input  logic [CELL_WIDTH-1:0]    ca_cell,
   output logic                     err_timeout
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   arb_state_t            r_state;
   logic [PTR_W-1:0]      r_ptr;
   logic [PTR_W-1:0]      r_gidx;
   logic [NUM_REQ-1:0]    r_grant;
   logic [NUM_REQ-1:0]    r_rsp_ready;
   logic [CELL_WIDTH-1:0] r_rsp_cell;
   logic [WIDTH-1:0]      r_ca_col;
   logic                  r_ca_ready;
   logic                  r_ca_ack;

   logic [NUM_REQ-1:0]    w_pick_grant;
   logic [PTR_W-1:0]      w_pick_idx;
   logic                  w_pick_any;
   logic [PTR_W-1:0]      w_next_ptr;

`ifdef ARB_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT + 1);
   logic [WDOG_W-1:0]     r_wdog;
   logic                  r_err;
`else
   logic                  w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT > 0);
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr_picker (
      .req   (req_valid),
      .ptr   (r_ptr),
      .grant (w_pick_grant),
      .idx   (w_pick_idx),
      .any   (w_pick_any)
   );

   // The requester just served drops to lowest priority next round.
   assign w_next_ptr = (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + PTR_W'(1);

   always_ff @(posedge in_clk) begin
      if (!in_reset) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_gidx      <= '0;
         r_grant     <= '0;
         r_rsp_ready <= '0;
         r_rsp_cell  <= '0;
         r_ca_col    <= '0;
         r_ca_ready  <= 1'b0;
         r_ca_ack    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_wdog      <= '0;
         r_err       <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ca_ready <= 1'b0;
               if (w_pick_any) begin
                  // Column is captured here so later req_col changes cannot reach the adder.
                  r_ca_col   <= req_col[int'(w_pick_idx)*WIDTH +: WIDTH];
                  r_grant    <= w_pick_grant;
                  r_gidx     <= w_pick_idx;
                  r_ca_ready <= 1'b1;
                  r_state    <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_ca_ready <= 1'b0;
`ifdef ARB_TIMEOUT_EN
               r_wdog     <= '0;
`endif
               r_state    <= ST_WAIT;
            end
            ST_WAIT: begin
               if (ca_out_ready) begin
                  r_rsp_cell  <= ca_cell;
                  r_rsp_ready <= r_grant;
                  r_state     <= ST_DELIVER;
               end
`ifdef ARB_TIMEOUT_EN
               // This is the TIMEOUT-th WAIT cycle with no result: give up with a qNaN.
               else if (r_wdog == WDOG_W'(TIMEOUT - 1)) begin
                  r_rsp_cell  <= CELL_WIDTH'(QNAN_CELL);
                  r_rsp_ready <= r_grant;
                  r_err       <= 1'b1;
                  r_state     <= ST_DELIVER;
               end else begin
                  r_wdog <= r_wdog + WDOG_W'(1);
               end
`endif
            end
            ST_DELIVER: begin
               if (rsp_ack[r_gidx]) begin
                  r_rsp_ready <= '0;
                  r_ca_ack    <= 1'b1;
                  r_state     <= ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               r_ca_ack <= 1'b0;
               // Waiting for out_ready to fall keeps a stale done from satisfying the next WAIT.
               if (!ca_out_ready) begin
                  r_grant <= '0;
                  r_ptr   <= w_next_ptr;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign grant     = r_grant;
   assign rsp_ready = r_rsp_ready;
   assign rsp_cell  = r_rsp_cell;
   assign ca_col    = r_ca_col;
   assign ca_ready  = r_ca_ready;
   assign ca_ack    = r_ca_ack;
`ifdef ARB_TIMEOUT_EN
   assign err_timeout = r_err;
`else
   assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_column_adder_arbiter.sv
// tb/tb_column_adder_arbiter.sv - directed self-checking bench for column_adder_arbiter
module tb_column_adder_arbiter;

   localparam int NR = 4;
   localparam int W  = 128;
   localparam logic [127:0] COL_A = {32'h4080_0000, 32'h4040_0000, 32'h4000_0000, 32'h3F80_0000};
   localparam logic [31:0]  SUM_A = 32'h4120_0000;

   logic            in_clk = 1'b0;
   logic            in_reset = 1'b0;
   logic [NR-1:0]   req_valid = '0;
   logic [NR*W-1:0] req_col = '0;
   logic [NR-1:0]   rsp_ack = '0;
   logic [NR-1:0]   grant;
   logic [NR-1:0]   rsp_ready;
   logic [31:0]     rsp_cell;
   logic [W-1:0]    ca_col;
   logic            ca_ready;
   logic            ca_ack;
   logic            ca_out_ready;
   logic [31:0]     ca_cell;
   logic            err_timeout;

   int n_vec = 0;
   int n_err = 0;
   int pulses = 0;
   logic stall = 1'b0;

   column_adder_arbiter #(
      .NUM_REQ(NR), .SIZE(4), .CELL_WIDTH(32), .WIDTH(W), .TIMEOUT(16)
   ) dut (
      .in_clk(in_clk), .in_reset(in_reset), .req_valid(req_valid), .req_col(req_col),
      .rsp_ack(rsp_ack), .grant(grant), .rsp_ready(rsp_ready), .rsp_cell(rsp_cell),
      .ca_col(ca_col), .ca_ready(ca_ready), .ca_ack(ca_ack), .ca_out_ready(ca_out_ready),
      .ca_cell(ca_cell), .err_timeout(err_timeout)
   );

   always #5 in_clk = ~in_clk;

   // Column adder stand-in: fixed latency, results for the known columns only.
   logic         m_busy;
   int           m_cnt;
   logic [W-1:0] m_col;
   always @(posedge in_clk) begin
      if (!in_reset) begin
         ca_out_ready <= 1'b0;
         ca_cell      <= '0;
         m_busy       <= 1'b0;
         m_cnt        <= 0;
         m_col        <= '0;
      end else if (ca_ready && !m_busy && !stall) begin
         m_busy <= 1'b1;
         m_cnt  <= 3;
         m_col  <= ca_col;
      end else if (m_busy && !ca_out_ready) begin
         if (m_cnt == 0) begin
            ca_out_ready <= 1'b1;
            ca_cell      <= (m_col == COL_A) ? SUM_A : (m_col == '0) ? 32'h0 : 32'hDEAD_BEEF;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end else if (ca_out_ready && ca_ack) begin
         ca_out_ready <= 1'b0;
         m_busy       <= 1'b0;
      end
   end

   always @(posedge in_clk) begin
      if (ca_ready === 1'b1) pulses <= pulses + 1;
   end

   task automatic tick();
      @(posedge in_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"}, 128'(grant), 128'(0));
      check({tag, "_rsp_ready"}, 128'(rsp_ready), 128'(0));
      check({tag, "_rsp_cell"}, 128'(rsp_cell), 128'(0));
      check({tag, "_ca_col"}, ca_col, 128'(0));
      check({tag, "_ca_ready"}, 128'(ca_ready), 128'(0));
      check({tag, "_ca_ack"}, 128'(ca_ack), 128'(0));
      check({tag, "_err"}, 128'(err_timeout), 128'(0));
   endtask

   task automatic wait_grant(input string tag);
      int n = 0;
      while (grant === '0 && n < 50) begin tick(); n++; end
      if (grant === '0) check({tag, "_grant_timeout"}, 128'(0), 128'(1));
   endtask

   // One full transaction: grant, result, optional late ack, release.
   task automatic serve(input string tag, input logic [NR-1:0] exp_grant, input logic [31:0] exp_cell,
                        input int ack_delay, input logic [NR-1:0] after_req, input logic [NR*W-1:0] after_col);
      int p0;
      int n;
      p0 = pulses;
      wait_grant(tag);
      check({tag, "_grant"}, 128'(grant), 128'(exp_grant));
      check({tag, "_ca_ready_on"}, 128'(ca_ready), 128'(1));
      req_valid = after_req;
      req_col   = after_col;
      tick();
      check({tag, "_ca_ready_off"}, 128'(ca_ready), 128'(0));
      n = 0;
      while (rsp_ready === '0 && n < 100) begin tick(); n++; end
      check({tag, "_rsp_ready"}, 128'(rsp_ready), 128'(exp_grant));
      check({tag, "_rsp_cell"}, 128'(rsp_cell), 128'(exp_cell));
      for (int i = 0; i < ack_delay; i++) begin
         rsp_ack = ~exp_grant;
         tick();
         check({tag, "_hold_ready"}, 128'(rsp_ready), 128'(exp_grant));
         check({tag, "_hold_cell"}, 128'(rsp_cell), 128'(exp_cell));
         check({tag, "_hold_ca_ack"}, 128'(ca_ack), 128'(0));
         check({tag, "_hold_grant"}, 128'(grant), 128'(exp_grant));
      end
      rsp_ack = exp_grant;
      tick();
      rsp_ack = '0;
      check({tag, "_ca_ack"}, 128'(ca_ack), 128'(1));
      check({tag, "_rsp_drop"}, 128'(rsp_ready), 128'(0));
      n = 0;
      while (grant !== '0 && n < 50) begin tick(); n++; end
      check({tag, "_release"}, 128'(grant), 128'(0));
      check({tag, "_pulses"}, 128'(pulses - p0), 128'(1));
   endtask

   task automatic do_reset();
      in_reset = 1'b0;
      req_valid = '0;
      rsp_ack = '0;
      tick();
      tick();
      in_reset = 1'b1;
   endtask

   logic [NR*W-1:0] cols;

   initial begin
      do_reset();
      check_reset_outputs("reset");

      // 1 single requester
      cols = '0;
      cols[0*W +: W] = COL_A;
      req_col = cols;
      req_valid = 4'b0001;
      serve("t1", 4'b0001, SUM_A, 0, 4'b0000, cols);

      // 2 contention from pointer 0
      do_reset();
      cols = {COL_A, COL_A, COL_A, COL_A};
      req_col = cols;
      req_valid = 4'b1111;
      serve("t2a", 4'b0001, SUM_A, 0, 4'b1111, cols);
      serve("t2b", 4'b0010, SUM_A, 0, 4'b1111, cols);
      serve("t2c", 4'b0100, SUM_A, 0, 4'b1111, cols);
      serve("t2d", 4'b1000, SUM_A, 0, 4'b1111, cols);
      serve("t2e", 4'b0001, SUM_A, 0, 4'b0000, cols);

      // 3 late ack from requester 2 while others request (ptr=1)
      req_valid = 4'b0100;
      serve("t3a", 4'b0100, SUM_A, 20, 4'b1011, cols);
      serve("t3b", 4'b1000, SUM_A, 0, 4'b0000, cols);

      // 4 column changed after grant (ptr=0)
      cols = '0;
      cols[1*W +: W] = COL_A;
      req_col = cols;
      req_valid = 4'b0010;
      serve("t4a", 4'b0010, SUM_A, 0, 4'b0010, '0);
      serve("t4b", 4'b0010, 32'h0, 0, 4'b0000, '0);

      // 5 reset in WAIT (ptr=2 before reset)
      cols = {COL_A, COL_A, COL_A, COL_A};
      req_col = cols;
      req_valid = 4'b0001;
      wait_grant("t5");
      check("t5_grant", 128'(grant), 128'(4'b0001));
      req_valid = '0;
      tick();
      tick();
      in_reset = 1'b0;
      tick();
      check_reset_outputs("t5_rst");
      in_reset = 1'b1;
      req_valid = 4'b0110;
      serve("t5_ptr0", 4'b0010, SUM_A, 0, 4'b0000, cols);
      req_valid = 4'b1000;
      serve("t5b", 4'b1000, SUM_A, 0, 4'b0000, cols);

`ifdef ARB_TIMEOUT_EN
      // 6 watchdog with a stalled adder (ptr=0)
      stall = 1'b1;
      req_valid = 4'b0001;
      wait_grant("t6");
      check("t6_grant", 128'(grant), 128'(4'b0001));
      req_valid = '0;
      for (int i = 0; i < 16; i++) tick();
      check("t6_not_yet", 128'(rsp_ready), 128'(0));
      check("t6_err_low", 128'(err_timeout), 128'(0));
      tick();
      check("t6_rsp_ready", 128'(rsp_ready), 128'(4'b0001));
      check("t6_qnan", 128'(rsp_cell), 128'(32'h7FC0_0000));
      check("t6_err", 128'(err_timeout), 128'(1));
      rsp_ack = 4'b0001;
      tick();
      rsp_ack = '0;
      tick();
      tick();
      check("t6_release", 128'(grant), 128'(0));
      check("t6_err_sticky", 128'(err_timeout), 128'(1));
      stall = 1'b0;
`else
      check("err_tied0", 128'(err_timeout), 128'(0));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
